// File: rtl/udp_port_filter_if.sv
// Header plus payload bundle for one side of the UDP port filter.
// Header: hdr_valid/hdr_ready handshake, dest_port, and the opaque hdr_meta
// that carries every other header field.
// Payload: AXI-stream style tdata/tvalid/tready/tlast/tuser, 8 bits wide.
// The master modport is the side that produces header and payload.
interface udp_port_filter_if #(
   parameter int META_WIDTH = 352
) ();
   logic                  hdr_valid;
   logic                  hdr_ready;
   logic [15:0]           dest_port;
   logic [META_WIDTH-1:0] hdr_meta;
   logic [7:0]            tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output hdr_valid, dest_port, hdr_meta, tdata, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );

   modport slave (
      input  hdr_valid, dest_port, hdr_meta, tdata, tvalid, tlast, tuser,
      output hdr_ready, tready
   );
endinterface

// File: rtl/udp_port_filter.sv
// UDP destination-port filter. Each incoming header is compared against
// cfg_port under cfg_port_mask. A matching header is registered and
// presented on m_udp, and its payload is passed straight through. A header
// that does not match is swallowed, its payload is consumed and discarded,
// and drop_count is incremented (it saturates at 0xFFFF).
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   s_udp (slave)   incoming header and payload
//   m_udp (master)  outgoing header and payload
//   cfg_port        port value to match
//   cfg_port_mask   per-bit compare enable, 1 = compare this bit
//   drop_count      number of dropped frames, saturating
//   busy            high while a frame is in progress
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a header; payload is stalled
// FORWARD | matched frame; payload passes through to m_udp
// DROP    | unmatched frame; payload is accepted and discarded
module udp_port_filter #(
   parameter int META_WIDTH = 352
) (
   input  logic                  clk,
   input  logic                  rst,
   udp_port_filter_if.slave      s_udp,
   udp_port_filter_if.master     m_udp,
   input  logic [15:0]           cfg_port,
   input  logic [15:0]           cfg_port_mask,
   output logic [15:0]           drop_count,
   output logic                  busy
);
   typedef enum logic [1:0] {ST_IDLE, ST_FORWARD, ST_DROP} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_m_valid;
   logic [15:0]           r_dest_port;
   logic [META_WIDTH-1:0] r_meta;
   logic [15:0]           r_drop_count;
   logic                  w_hdr_ready;
   logic                  w_hdr_fire;
   logic                  w_match;
   logic                  w_s_tready;
   logic                  w_m_tvalid;

   // A header is taken only from IDLE, and only once the previous output
   // header has been accepted downstream. Holding it off while that header
   // is pending means the registered fields are never overwritten. Header
   // acceptance is also blocked while rst is high.
   assign w_hdr_ready = (r_state == ST_IDLE) && !r_m_valid && !rst;
   assign w_hdr_fire  = s_udp.hdr_valid && w_hdr_ready;
   assign w_match     = ((s_udp.dest_port ^ cfg_port) & cfg_port_mask) == 16'h0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_s_tready   = 1'b0;
      w_m_tvalid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_hdr_fire) w_state_next = w_match ? ST_FORWARD : ST_DROP;
         end
         ST_FORWARD: begin
            w_m_tvalid = s_udp.tvalid;
            w_s_tready = m_udp.tready;
            if (s_udp.tvalid && m_udp.tready && s_udp.tlast) w_state_next = ST_IDLE;
         end
         ST_DROP: begin
            w_s_tready = 1'b1;
            if (s_udp.tvalid && s_udp.tlast) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid    <= 1'b0;
         r_dest_port  <= 16'h0000;
         r_meta       <= '0;
         r_drop_count <= 16'h0000;
      end else begin
         if (w_hdr_fire && w_match) begin
            r_m_valid   <= 1'b1;
            r_dest_port <= s_udp.dest_port;
            r_meta      <= s_udp.hdr_meta;
         end else if (r_m_valid && m_udp.hdr_ready) begin
            r_m_valid <= 1'b0;
         end
         if (w_hdr_fire && !w_match && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign s_udp.hdr_ready = w_hdr_ready;
   assign s_udp.tready    = w_s_tready;
   assign m_udp.hdr_valid = r_m_valid;
   assign m_udp.dest_port = r_dest_port;
   assign m_udp.hdr_meta  = r_meta;
   // Data, tlast and tuser are always driven straight through. They only
   // mean something when tvalid is high, and tvalid is gated by the state.
   assign m_udp.tdata     = s_udp.tdata;
   assign m_udp.tlast     = s_udp.tlast;
   assign m_udp.tuser     = s_udp.tuser;
   assign m_udp.tvalid    = w_m_tvalid;
   assign drop_count      = r_drop_count;
   assign busy            = (r_state != ST_IDLE);
endmodule

// File: doc/udp_port_filter.md
UDP_PORT_FILTER -- requirements
Module: udp_port_filter

Interface
REQ-001 Parameter META_WIDTH, default 352: width of the packed non-port UDP/IP/Ethernet header fields carried alongside dest port.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_udp_hdr_valid  input  1  input header valid.
REQ-005 s_udp_hdr_ready  output  1  input header ready.
REQ-006 s_udp_dest_port  input  16  input UDP destination port.
REQ-007 s_udp_hdr_meta  input  META_WIDTH  all other header fields, opaque.
REQ-008 s_udp_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  input payload stream.
REQ-009 m_udp_hdr_valid  output  1  output header valid.
REQ-010 m_udp_hdr_ready  input  1  output header ready.
REQ-011 m_udp_dest_port  output  16  registered dest port.
REQ-012 m_udp_hdr_meta  output  META_WIDTH  registered meta fields.
REQ-013 m_udp_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  output payload stream.
REQ-014 cfg_port  input  16  match value.
REQ-015 cfg_port_mask  input  16  per-bit compare enable (1 = compare).
REQ-016 drop_count  output  16  frames dropped, saturating.
REQ-017 busy  output  1  high while state != IDLE.

Function
REQ-018 States IDLE, FORWARD, DROP; reset state IDLE.
REQ-019 IDLE: s_udp_hdr_ready = !m_udp_hdr_valid; FORWARD/DROP: s_udp_hdr_ready = 0.
REQ-020 Header handshake (valid & ready) evaluates match = ((s_udp_dest_port ^ cfg_port) & cfg_port_mask) == 0; cfg_* sampled only at that cycle.
REQ-021 Match: dest port and meta registered, m_udp_hdr_valid = 1 from next cycle, state -> FORWARD.
REQ-022 No match: header not forwarded, drop_count += 1 (saturate at 0xFFFF, no wrap), state -> DROP.
REQ-023 m_udp_hdr_valid clears on cycle after m_udp_hdr_valid & m_udp_hdr_ready; registered fields hold stable while valid high.
REQ-024 FORWARD: combinational passthrough — m_tdata/tlast/tuser = s_*, m_tvalid = s_tvalid, s_tready = m_tready; payload may flow before output header is accepted.
REQ-025 FORWARD: beat with s_tvalid & s_tready & s_tlast -> IDLE next cycle.
REQ-026 DROP: s_tready = 1, m_tvalid = 0; beat with s_tvalid & s_tlast -> IDLE next cycle; tuser ignored.
REQ-027 IDLE: s_tready = 0, m_tvalid = 0; payload is never consumed without an owning header.
REQ-028 A new header is not accepted in the same cycle as the tlast beat; earliest acceptance is the following cycle (one-cycle bubble per frame).
REQ-029 New header in IDLE is blocked while previous m_udp_hdr_valid still pending (no overwrite).
REQ-030 cfg_port_mask = 0 forwards every frame; 0xFFFF requires exact match.
REQ-031 Zero-length-payload frames are not supported; each header is followed by at least one beat carrying tlast.

Reset
REQ-032 While rst high: state IDLE, m_udp_hdr_valid 0, m_udp_dest_port 0, m_udp_hdr_meta 0, drop_count 0, busy 0, s_udp_hdr_ready 0; m_tvalid and s_tready 0.
REQ-033 Reset mid-frame aborts the frame; after release the block waits in IDLE for a new header, remaining beats of the aborted frame stall (tready 0).

Verification
REQ-034 cfg_port 0x1234, mask 0xFFFF; header port 0x1234, 4-byte payload 01 02 03 04 -> one output header port 0x1234, meta identical, payload 01..04 with tlast on 04, drop_count 0.
REQ-035 Same cfg; header port 0x1235, 3-byte payload -> no m_udp_hdr_valid, no m_tvalid, all 3 beats consumed, drop_count 1, busy low after tlast.
REQ-036 mask 0xFF00, cfg_port 0x1200; ports 0x12AB then 0x13AB back to back -> first forwarded, second dropped; second header accepted exactly 1 cycle after first tlast.
REQ-037 Matching frame with m_udp_hdr_ready held 0 for 10 cycles, m_tready toggling 1/0 -> payload completes in order, header held stable, next header not accepted until m_udp_hdr_ready pulses.
REQ-038 Force drop_count to 0xFFFF via 65535 dropped frames, then one more -> drop_count stays 0xFFFF.
REQ-039 Assert rst for 1 cycle after 2 of 5 beats of a forwarded frame -> all outputs at reset values, frame discarded, next valid header processed normally.
